// File: rtl/digit_recog_pkg.sv
// Shared types, phase codes and the crossing-feature decode table for the digit recogniser.
package digit_recog_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARM    = 3'd1,
      PRIME  = 3'd2,
      SCAN   = 3'd3,
      COUNT  = 3'd4,
      DECODE = 3'd5,
      DONE   = 3'd6
   } state_t;

   localparam logic [2:0] FRAME_IDLE  = 3'd0;
   localparam logic [2:0] FRAME_PRIME = 3'd1;
   localparam logic [2:0] FRAME_SCAN  = 3'd2;
   localparam logic [2:0] FRAME_COUNT = 3'd3;

   localparam logic [3:0] DIGIT_NONE = 4'hF;

   // First match wins; the half-side flags only separate the y3/x1=1/x2=1 family.
   function automatic logic [3:0] decode_digit(input logic [3:0] y,
                                               input logic [3:0] x1,
                                               input logic [3:0] x2,
                                               input logic       x1_l,
                                               input logic       x1_r,
                                               input logic       x2_l,
                                               input logic       x2_r);
      logic [3:0] d;
      d = DIGIT_NONE;
      if      (y == 4'd2 && x1 == 4'd2 && x2 == 4'd2)                 d = 4'd0;
      else if (y == 4'd1 && x1 == 4'd1 && x2 == 4'd1)                 d = 4'd1;
      else if (y == 4'd3 && x1 == 4'd1 && x2 == 4'd1 && x1_r && x2_l) d = 4'd2;
      else if (y == 4'd3 && x1 == 4'd1 && x2 == 4'd1 && x1_r && x2_r) d = 4'd3;
      else if (y == 4'd2 && x1 == 4'd2 && x2 == 4'd1)                 d = 4'd4;
      else if (y == 4'd3 && x1 == 4'd1 && x2 == 4'd1 && x1_l && x2_r) d = 4'd5;
      else if (y == 4'd3 && x1 == 4'd1 && x2 == 4'd2)                 d = 4'd6;
      else if (y == 4'd2 && x1 == 4'd1 && x2 == 4'd1)                 d = 4'd7;
      else if (y == 4'd3 && x1 == 4'd2 && x2 == 4'd2)                 d = 4'd8;
      else if (y == 4'd3 && x1 == 4'd2 && x2 == 4'd1)                 d = 4'd9;
      return d;
   endfunction

endpackage

// File: rtl/vsync_edge_det.sv
// Registers a frame sync and flags its falling/rising edges against the previous sample.
module vsync_edge_det (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_vsync,
   output logic o_fall,
   output logic o_rise
);

   logic r_vsync_q;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_vsync_q <= 1'b0;
      end else begin
         r_vsync_q <= i_vsync;
      end
   end

   assign o_fall = !i_vsync &&  r_vsync_q;
   assign o_rise =  i_vsync && !r_vsync_q;

endmodule

// File: rtl/digit_recog_sequencer.sv
// Frame-level controller: latches the box, steps frame_cnt over three frames, then decodes
// the recogniser's crossing features into a digit.
module digit_recog_sequencer #(
   parameter logic [11:0] MIN_W        = 12'd8,
   parameter logic [11:0] MIN_H        = 12'd12,
   parameter logic [31:0] TIMEOUT_CLKS = 32'd2000000,
   parameter logic        AUTO_RESTART = 1'b0
) (
   input  logic        pixel_clk,
   input  logic        reset,
   input  logic        start,
   input  logic        i_vsync,
   input  logic        bbox_valid,
   input  logic [11:0] hcount_l,
   input  logic [11:0] hcount_r,
   input  logic [11:0] vcount_l,
   input  logic [11:0] vcount_r,
   input  logic [3:0]  x1,
   input  logic [3:0]  x2,
   input  logic [3:0]  y,
   input  logic        x1_l,
   input  logic        x1_r,
   input  logic        x2_l,
   input  logic        x2_r,
   output logic [2:0]  frame_cnt,
   output logic [11:0] box_hl,
   output logic [11:0] box_hr,
   output logic [11:0] box_vl,
   output logic [11:0] box_vr,
   output logic        busy,
   output logic [3:0]  digit,
   output logic        digit_valid,
   output logic        digit_err
);

   import digit_recog_pkg::*;

   state_t      r_state, w_state_d;
   logic [2:0]  r_frame_cnt, w_frame_cnt_d;
   logic [11:0] r_box_hl, r_box_hr, r_box_vl, r_box_vr;
   logic        r_busy, w_busy_d;
   logic [3:0]  r_digit, w_digit_d;
   logic        r_digit_valid, w_digit_valid_d;
   logic        r_digit_err, w_digit_err_d;
   logic [31:0] r_wdog;

   logic        w_vs_fall;
   logic        w_unused_vs_rise;
   logic        w_box_ok;
   logic        w_box_load;
   logic        w_in_run;
   logic        w_timeout;
   logic [3:0]  w_digit_dec;

   vsync_edge_det u_vsync_edge_det (
      .i_clk   (pixel_clk),
      .i_rst   (reset),
      .i_vsync (i_vsync),
      .o_fall  (w_vs_fall),
      .o_rise  (w_unused_vs_rise)
   );

   // Reversed edges are rejected rather than letting the subtraction wrap into a huge size.
   assign w_box_ok = bbox_valid
                     && (hcount_r >= hcount_l) && ((hcount_r - hcount_l) >= MIN_W)
                     && (vcount_r >= vcount_l) && ((vcount_r - vcount_l) >= MIN_H);

   assign w_in_run    = (r_state == ARM) || (r_state == PRIME) ||
                        (r_state == SCAN) || (r_state == COUNT);
   assign w_timeout   = w_in_run && !w_vs_fall && (r_wdog >= TIMEOUT_CLKS);
   assign w_digit_dec = decode_digit(y, x1, x2, x1_l, x1_r, x2_l, x2_r);

   always_comb begin
      w_state_d       = r_state;
      w_box_load      = 1'b0;
      w_digit_d       = r_digit;
      w_digit_err_d   = r_digit_err;
      w_digit_valid_d = 1'b0;

      case (r_state)
         IDLE: begin
            if (start) begin
               if (w_box_ok) begin
                  w_box_load    = 1'b1;
                  w_digit_d     = DIGIT_NONE;
                  w_digit_err_d = 1'b0;
                  w_state_d     = ARM;
               end else begin
                  w_digit_d       = DIGIT_NONE;
                  w_digit_err_d   = 1'b1;
                  w_digit_valid_d = 1'b1;
               end
            end
         end
         ARM: begin
            if (w_vs_fall) w_state_d = PRIME;
         end
         PRIME: begin
            if (w_vs_fall) w_state_d = SCAN;
         end
         SCAN: begin
            if (w_vs_fall) w_state_d = COUNT;
         end
         COUNT: begin
            if (w_vs_fall) w_state_d = DECODE;
         end
         DECODE: begin
            w_digit_d       = w_digit_dec;
            w_digit_err_d   = (w_digit_dec == DIGIT_NONE);
            w_digit_valid_d = 1'b1;
            w_state_d       = DONE;
         end
         DONE: begin
            if (AUTO_RESTART && w_box_ok) begin
               w_box_load    = 1'b1;
               w_digit_d     = DIGIT_NONE;
               w_digit_err_d = 1'b0;
               w_state_d     = ARM;
            end else begin
               w_state_d = IDLE;
            end
         end
         default: w_state_d = IDLE;
      endcase

      if (w_timeout) begin
         w_digit_d       = DIGIT_NONE;
         w_digit_err_d   = 1'b1;
         w_digit_valid_d = 1'b1;
         w_state_d       = DONE;
      end
   end

   always_comb begin
      w_frame_cnt_d = FRAME_IDLE;
      case (w_state_d)
         PRIME:   w_frame_cnt_d = FRAME_PRIME;
         SCAN:    w_frame_cnt_d = FRAME_SCAN;
         COUNT:   w_frame_cnt_d = FRAME_COUNT;
         default: w_frame_cnt_d = FRAME_IDLE;
      endcase
      w_busy_d = (w_state_d == ARM) || (w_state_d == PRIME) || (w_state_d == SCAN) ||
                 (w_state_d == COUNT) || (w_state_d == DECODE);
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         r_state       <= IDLE;
         r_frame_cnt   <= FRAME_IDLE;
         r_busy        <= 1'b0;
         r_digit       <= DIGIT_NONE;
         r_digit_valid <= 1'b0;
         r_digit_err   <= 1'b0;
      end else begin
         r_state       <= w_state_d;
         r_frame_cnt   <= w_frame_cnt_d;
         r_busy        <= w_busy_d;
         r_digit       <= w_digit_d;
         r_digit_valid <= w_digit_valid_d;
         r_digit_err   <= w_digit_err_d;
      end
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         r_box_hl <= 12'd0;
         r_box_hr <= 12'd0;
         r_box_vl <= 12'd0;
         r_box_vr <= 12'd0;
      end else if (w_box_load) begin
         r_box_hl <= hcount_l;
         r_box_hr <= hcount_r;
         r_box_vl <= vcount_l;
         r_box_vr <= vcount_r;
      end
   end

   always_ff @(posedge pixel_clk or posedge reset) begin
      if (reset) begin
         r_wdog <= 32'd0;
      end else if (!w_in_run || w_vs_fall) begin
         r_wdog <= 32'd0;
      end else begin
         r_wdog <= r_wdog + 32'd1;
      end
   end

   assign frame_cnt   = r_frame_cnt;
   assign box_hl      = r_box_hl;
   assign box_hr      = r_box_hr;
   assign box_vl      = r_box_vl;
   assign box_vr      = r_box_vr;
   assign busy        = r_busy;
   assign digit       = r_digit;
   assign digit_valid = r_digit_valid;
   assign digit_err   = r_digit_err;

endmodule

// File: tb/tb_digit_recog_sequencer.sv
// Scoreboarded bench: expected {err,digit} pushed at each start, popped on every digit_valid.
module tb_digit_recog_sequencer;

   localparam logic [31:0] TMO = 32'd300;

   logic        pixel_clk;
   logic        reset;
   logic        start;
   logic        i_vsync;
   logic        bbox_valid;
   logic [11:0] hcount_l, hcount_r, vcount_l, vcount_r;
   logic [3:0]  x1, x2, y;
   logic        x1_l, x1_r, x2_l, x2_r;
   logic [2:0]  frame_cnt;
   logic [11:0] box_hl, box_hr, box_vl, box_vr;
   logic        busy;
   logic [3:0]  digit;
   logic        digit_valid;
   logic        digit_err;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [4:0]  sb_q[$];
   logic [4:0]  exp_v;
   logic [19:0] tab[10];
   logic [19:0] ent;

   digit_recog_sequencer #(
      .MIN_W        (12'd8),
      .MIN_H        (12'd12),
      .TIMEOUT_CLKS (TMO),
      .AUTO_RESTART (1'b0)
   ) dut (
      .pixel_clk   (pixel_clk),
      .reset       (reset),
      .start       (start),
      .i_vsync     (i_vsync),
      .bbox_valid  (bbox_valid),
      .hcount_l    (hcount_l),
      .hcount_r    (hcount_r),
      .vcount_l    (vcount_l),
      .vcount_r    (vcount_r),
      .x1          (x1),
      .x2          (x2),
      .y           (y),
      .x1_l        (x1_l),
      .x1_r        (x1_r),
      .x2_l        (x2_l),
      .x2_r        (x2_r),
      .frame_cnt   (frame_cnt),
      .box_hl      (box_hl),
      .box_hr      (box_hr),
      .box_vl      (box_vl),
      .box_vr      (box_vr),
      .busy        (busy),
      .digit       (digit),
      .digit_valid (digit_valid),
      .digit_err   (digit_err)
   );

   initial pixel_clk = 1'b0;
   always #5 pixel_clk = ~pixel_clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge pixel_clk) begin
      if (!reset && digit_valid) begin
         if (sb_q.size() == 0) begin
            check_eq("spurious_pulse", {31'd0, digit_valid}, 32'd0);
         end else begin
            exp_v = sb_q.pop_front();
            check_eq("pulse_digit", {28'd0, digit}, {28'd0, exp_v[3:0]});
            check_eq("pulse_err", {31'd0, digit_err}, {31'd0, exp_v[4]});
            check_eq("pulse_busy", {31'd0, busy}, 32'd0);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge pixel_clk);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic frame();
      i_vsync = 1'b1;
      tick(4);
      i_vsync = 1'b0;
      tick(16);
   endtask

   task automatic set_box(input logic [11:0] hl, input logic [11:0] hr, input logic [11:0] vl,
                          input logic [11:0] vr, input logic v);
      hcount_l = hl;
      hcount_r = hr;
      vcount_l = vl;
      vcount_r = vr;
      bbox_valid = v;
   endtask

   task automatic set_feat(input logic [3:0] fy, input logic [3:0] fx1, input logic [3:0] fx2,
                           input logic [3:0] fl);
      y = fy;
      x1 = fx1;
      x2 = fx2;
      x1_l = fl[3];
      x1_r = fl[2];
      x2_l = fl[1];
      x2_r = fl[0];
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_fc"}, {29'd0, frame_cnt}, 32'd0);
      check_eq({tag, "_box"}, {box_hl, box_hr, box_vl, box_vr} == 48'd0 ? 32'd0 : 32'd1, 32'd0);
      check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
      check_eq({tag, "_digit"}, {28'd0, digit}, 32'hF);
      check_eq({tag, "_dv"}, {31'd0, digit_valid}, 32'd0);
      check_eq({tag, "_err"}, {31'd0, digit_err}, 32'd0);
   endtask

   initial begin
      // {y, x1, x2, flags(x1_l,x1_r,x2_l,x2_r), expected digit}
      tab = '{20'h22200, 20'h31162, 20'h31153, 20'h22104, 20'h31195,
              20'h31206, 20'h21107, 20'h32208, 20'h3110F, 20'h311F2};
      reset = 1'b1;
      start = 1'b0;
      i_vsync = 1'b0;
      set_box(12'd0, 12'd0, 12'd0, 12'd0, 1'b0);
      set_feat(4'd0, 4'd0, 4'd0, 4'd0);
      tick(3);
      check_reset_vals("reset");
      reset = 1'b0;
      tick(2);

      // Full run, 40x60 box, features for 9
      set_box(12'd100, 12'd140, 12'd50, 12'd110, 1'b1);
      set_feat(4'd3, 4'd2, 4'd1, 4'd0);
      sb_q.push_back({1'b0, 4'd9});
      pulse_start();
      check_eq("t1_arm_busy", {31'd0, busy}, 32'd1);
      check_eq("t1_arm_fc", {29'd0, frame_cnt}, 32'd0);
      check_eq("t1_box_hl", {20'd0, box_hl}, 32'd100);
      check_eq("t1_box_hr", {20'd0, box_hr}, 32'd140);
      check_eq("t1_box_vl", {20'd0, box_vl}, 32'd50);
      check_eq("t1_box_vr", {20'd0, box_vr}, 32'd110);
      for (int f = 1; f <= 3; f++) begin
         frame();
         check_eq($sformatf("t1_fc%0d", f), {29'd0, frame_cnt}, f);
      end
      frame();
      check_eq("t1_sb", sb_q.size(), 32'd0);
      check_eq("t1_fc_end", {29'd0, frame_cnt}, 32'd0);
      check_eq("t1_busy_end", {31'd0, busy}, 32'd0);
      check_eq("t1_digit", {28'd0, digit}, 32'd9);
      check_eq("t1_err", {31'd0, digit_err}, 32'd0);

      // Start without a valid box
      set_box(12'd300, 12'd340, 12'd50, 12'd110, 1'b0);
      sb_q.push_back({1'b1, 4'hF});
      pulse_start();
      tick(3);
      check_eq("t2_sb", sb_q.size(), 32'd0);
      check_eq("t2_fc", {29'd0, frame_cnt}, 32'd0);
      check_eq("t2_busy", {31'd0, busy}, 32'd0);
      check_eq("t2_err", {31'd0, digit_err}, 32'd1);
      check_eq("t2_digit", {28'd0, digit}, 32'hF);

      // Box too narrow
      set_box(12'd200, 12'd205, 12'd50, 12'd110, 1'b1);
      sb_q.push_back({1'b1, 4'hF});
      pulse_start();
      tick(3);
      check_eq("t3_sb", sb_q.size(), 32'd0);
      check_eq("t3_box_hl", {20'd0, box_hl}, 32'd100);
      check_eq("t3_box_hr", {20'd0, box_hr}, 32'd140);
      check_eq("t3_busy", {31'd0, busy}, 32'd0);
      check_eq("t3_err", {31'd0, digit_err}, 32'd1);

      // Watchdog: vsync stops after SCAN is entered
      set_box(12'd10, 12'd30, 12'd20, 12'd40, 1'b1);
      sb_q.push_back({1'b1, 4'hF});
      pulse_start();
      check_eq("t4_err_clr", {31'd0, digit_err}, 32'd0);
      frame();
      frame();
      check_eq("t4_fc_scan", {29'd0, frame_cnt}, 32'd2);
      tick(int'(TMO) + 20);
      check_eq("t4_sb", sb_q.size(), 32'd0);
      check_eq("t4_fc", {29'd0, frame_cnt}, 32'd0);
      check_eq("t4_err", {31'd0, digit_err}, 32'd1);
      check_eq("t4_busy", {31'd0, busy}, 32'd0);

      // Second start during SCAN is ignored
      set_feat(4'd1, 4'd1, 4'd1, 4'd0);
      sb_q.push_back({1'b0, 4'd1});
      pulse_start();
      frame();
      frame();
      set_box(12'd7, 12'd90, 12'd3, 12'd99, 1'b1);
      pulse_start();
      tick(1);
      check_eq("t5_box_hl", {20'd0, box_hl}, 32'd10);
      check_eq("t5_box_vr", {20'd0, box_vr}, 32'd40);
      check_eq("t5_fc", {29'd0, frame_cnt}, 32'd2);
      check_eq("t5_busy", {31'd0, busy}, 32'd1);
      frame();
      check_eq("t5_fc3", {29'd0, frame_cnt}, 32'd3);
      frame();
      tick(3);
      check_eq("t5_sb", sb_q.size(), 32'd0);
      check_eq("t5_digit", {28'd0, digit}, 32'd1);

      // Reset in COUNT, then an unmatched feature set
      pulse_start();
      repeat (3) frame();
      check_eq("t6_fc3", {29'd0, frame_cnt}, 32'd3);
      reset = 1'b1;
      #1;
      check_reset_vals("t6_async");
      tick(1);
      check_reset_vals("t6_held");
      reset = 1'b0;
      tick(1);
      frame();
      set_feat(4'd2, 4'd1, 4'd2, 4'd0);
      sb_q.push_back({1'b1, 4'hF});
      pulse_start();
      repeat (4) frame();
      tick(2);
      check_eq("t6_sb", sb_q.size(), 32'd0);
      check_eq("t6_err", {31'd0, digit_err}, 32'd1);
      check_eq("t6_digit", {28'd0, digit}, 32'hF);

      // Decode table sweep
      for (int i = 0; i < 10; i++) begin
         ent = tab[i];
         set_feat(ent[19:16], ent[15:12], ent[11:8], ent[7:4]);
         sb_q.push_back({(ent[3:0] == 4'hF), ent[3:0]});
         pulse_start();
         repeat (4) frame();
         tick(2);
         check_eq($sformatf("sweep%0d_sb", i), sb_q.size(), 32'd0);
      end

      check_eq("final_sb", sb_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
